// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RESET,
    ST_WAIT_LOCK,
    ST_STABLE,
    ST_RELEASE,
    ST_RUN,
    ST_FAULT
  } sup_state_e;

  localparam int RETRY_W = 4;
  localparam int LOSS_W  = 8;

  // Bits needed for a counter that only ever holds 0 .. max_val-1.
  function automatic int cnt_w(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the supervisor and the PLL/clock-domain side.
interface pll_lock_supervisor_if #(
  parameter int NUM_CLOCKS = 4
);
  import pll_sup_pkg::*;

  logic                  pll_locked;
  logic                  sw_restart;
  logic                  pll_rst;
  logic [NUM_CLOCKS-1:0] clk_rst_n;
  logic                  ready;
  logic                  fault;
  logic [RETRY_W-1:0]    retry_count;
  logic [LOSS_W-1:0]     lock_loss_count;

  modport master (
    input  pll_locked, sw_restart,
    output pll_rst, clk_rst_n, ready, fault, retry_count, lock_loss_count
  );

  modport slave (
    output pll_locked, sw_restart,
    input  pll_rst, clk_rst_n, ready, fault, retry_count, lock_loss_count
  );
endinterface

// File: rtl/pll_lock_supervisor_sync_2ff.sv
// Two-flop synchroniser bringing the asynchronous PLL lock flag into refclk.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock qualification and staggered per-domain reset release,
// with retry/fault handling and lock-loss accounting.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int NUM_CLOCKS          = 4,
  parameter int PLL_RESET_CYCLES    = 8,
  parameter int LOCK_STABLE_CYCLES  = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 100000,
  parameter int MAX_RETRIES         = 3,
  parameter int STAGGER_CYCLES      = 4
) (
  input logic                   refclk,
  input logic                   rst_n,
  pll_lock_supervisor_if.master sup
);
  localparam int CW = cnt_w(max3(PLL_RESET_CYCLES, LOCK_TIMEOUT_CYCLES,
                                 STAGGER_CYCLES * NUM_CLOCKS));
  localparam int SW = cnt_w(LOCK_STABLE_CYCLES);

  localparam logic [CW-1:0]      RST_LAST  = CW'(PLL_RESET_CYCLES - 1);
  localparam logic [CW-1:0]      TO_LAST   = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0]      REL_LAST  = CW'(STAGGER_CYCLES * (NUM_CLOCKS - 1));
  localparam logic [SW-1:0]      STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  logic                  locked_s;
  sup_state_e            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-1:0]         stab_q, stab_d;
  logic [RETRY_W-1:0]    retry_q, retry_d, retry_inc;
  logic [LOSS_W-1:0]     loss_q, loss_d;
  logic                  go_retry, go_loss;
  logic                  pll_rst_q, pll_rst_d;
  logic [NUM_CLOCKS-1:0] clk_rst_n_q, clk_rst_n_d;
  logic                  ready_q, ready_d;
  logic                  fault_q, fault_d;

  sync_2ff u_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d_i   (sup.pll_locked),
    .q_o   (locked_s)
  );

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_PLL_RESET;
      cnt_q   <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      loss_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      loss_q  <= loss_d;
    end
  end

  // The timeout window spans WAIT_LOCK and STABLE together; only a completed
  // stability run escapes it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stab_d    = stab_q;
    retry_d   = retry_q;
    loss_d    = loss_q;
    retry_inc = retry_q + 1'b1;
    go_retry  = 1'b0;
    go_loss   = 1'b0;
    if (sup.sw_restart) begin
      state_d = ST_PLL_RESET;
      cnt_d   = '0;
      stab_d  = '0;
      retry_d = '0;
    end else begin
      unique case (state_q)
        ST_PLL_RESET: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == TO_LAST) begin
            go_retry = 1'b1;
          end else if (locked_s) begin
            state_d = ST_STABLE;
            stab_d  = '0;
          end
        end
        ST_STABLE: begin
          cnt_d = cnt_q + 1'b1;
          if (locked_s && stab_q == STAB_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
          end else if (cnt_q == TO_LAST) begin
            go_retry = 1'b1;
          end else if (!locked_s) begin
            state_d = ST_WAIT_LOCK;
            stab_d  = '0;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!locked_s) begin
            go_loss = 1'b1;
          end else if (cnt_q == REL_LAST) begin
            state_d = ST_RUN;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (!locked_s) go_loss = 1'b1;
        end
        default: ;
      endcase
      if (go_retry) begin
        retry_d = retry_inc;
        state_d = (retry_inc == RETRY_MAX) ? ST_FAULT : ST_PLL_RESET;
        cnt_d   = '0;
        stab_d  = '0;
      end
      if (go_loss) begin
        loss_d  = (loss_q == '1) ? loss_q : loss_q + 1'b1;
        state_d = ST_PLL_RESET;
        cnt_d   = '0;
        stab_d  = '0;
      end
    end
  end

  // Outputs are decoded from the next state so the registered copies line up
  // with state_q without an extra cycle of lag.
  always_comb begin
    pll_rst_d   = (state_d == ST_PLL_RESET) || (state_d == ST_FAULT);
    ready_d     = (state_d == ST_RUN);
    fault_d     = (state_d == ST_FAULT);
    clk_rst_n_d = '0;
    if (state_d == ST_RUN) begin
      clk_rst_n_d = '1;
    end else if (state_d == ST_RELEASE) begin
      for (int i = 0; i < NUM_CLOCKS; i++) begin
        clk_rst_n_d[i] = (cnt_d >= CW'(STAGGER_CYCLES * i));
      end
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst_q   <= 1'b1;
      clk_rst_n_q <= '0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      pll_rst_q   <= pll_rst_d;
      clk_rst_n_q <= clk_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  assign sup.pll_rst         = pll_rst_q;
  assign sup.clk_rst_n       = clk_rst_n_q;
  assign sup.ready           = ready_q;
  assign sup.fault           = fault_q;
  assign sup.retry_count     = retry_q;
  assign sup.lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: directed vector table, async-reset corner case,
// and randomized lock/restart traffic against a behavioural model.
module tb_pll_lock_supervisor;
  localparam int NC     = 4;
  localparam int P_RST  = 8;
  localparam int P_STAB = 16;
  localparam int P_TO   = 100;
  localparam int P_MAXR = 2;
  localparam int P_STAG = 4;

  localparam logic [18:0] RESET_VEC = {1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 8'h00};

  logic refclk = 1'b0;
  logic rst_n  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 refclk = ~refclk;

  pll_lock_supervisor_if #(.NUM_CLOCKS(NC)) sup_if ();

  pll_lock_supervisor #(
    .NUM_CLOCKS(NC), .PLL_RESET_CYCLES(P_RST), .LOCK_STABLE_CYCLES(P_STAB),
    .LOCK_TIMEOUT_CYCLES(P_TO), .MAX_RETRIES(P_MAXR), .STAGGER_CYCLES(P_STAG)
  ) dut (
    .refclk (refclk),
    .rst_n  (rst_n),
    .sup    (sup_if)
  );

  // ---------------- behavioural reference model ----------------
  localparam int M_RST = 0, M_WAIT = 1, M_STAB = 2, M_REL = 3, M_RUN = 4, M_FLT = 5;
  int m_phase, m_el, m_wait, m_good, m_tries, m_loss;
  bit m_hist[$];

  task automatic model_reset();
    m_phase = M_RST; m_el = 0; m_wait = 0; m_good = 0; m_tries = 0; m_loss = 0;
    m_hist.delete();
    m_hist.push_back(1'b0);
    m_hist.push_back(1'b0);
  endtask

  task automatic model_fail();
    m_tries++;
    m_phase = (m_tries == P_MAXR) ? M_FLT : M_RST;
    m_el = 0;
  endtask

  task automatic model_loss();
    if (m_loss < 255) m_loss++;
    m_phase = M_RST;
    m_el = 0;
  endtask

  // One refclk edge; p/sw are the input values presented before that edge.
  task automatic model_step(input bit p, input bit sw);
    bit ls;
    ls = m_hist.pop_front();
    m_hist.push_back(p);
    if (sw) begin
      m_phase = M_RST; m_el = 0; m_tries = 0; m_good = 0;
    end else begin
      case (m_phase)
        M_RST: begin
          m_el++;
          if (m_el == P_RST) begin m_phase = M_WAIT; m_wait = 0; end
        end
        M_WAIT: begin
          m_wait++;
          if (m_wait == P_TO) model_fail();
          else if (ls) begin m_phase = M_STAB; m_good = 0; end
        end
        M_STAB: begin
          m_wait++;
          if (ls && m_good + 1 == P_STAB) begin m_phase = M_REL; m_el = 0; end
          else if (m_wait == P_TO) model_fail();
          else if (!ls) m_phase = M_WAIT;
          else m_good++;
        end
        M_REL: begin
          if (!ls) model_loss();
          else if (m_el == P_STAG * (NC - 1)) begin m_phase = M_RUN; m_tries = 0; end
          else m_el++;
        end
        M_RUN: if (!ls) model_loss();
        default: ;
      endcase
    end
  endtask

  function automatic logic [18:0] model_outs();
    logic [NC-1:0] c;
    c = '0;
    for (int i = 0; i < NC; i++)
      c[i] = (m_phase == M_RUN) || (m_phase == M_REL && m_el >= P_STAG * i);
    return {(m_phase == M_RST || m_phase == M_FLT), c, (m_phase == M_RUN),
            (m_phase == M_FLT), 4'(m_tries), 8'(m_loss)};
  endfunction

  // ---------------- helpers ----------------
  function automatic logic [18:0] dut_outs();
    return {sup_if.pll_rst, sup_if.clk_rst_n, sup_if.ready, sup_if.fault,
            sup_if.retry_count, sup_if.lock_loss_count};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    bit p, sw;
    p  = sup_if.pll_locked;
    sw = sup_if.sw_restart;
    @(posedge refclk);
    model_step(p, sw);
    #1;
    check("model", dut_outs(), model_outs());
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    sup_if.pll_locked = 1'b0;
    sup_if.sw_restart = 1'b0;
    model_reset();
    #1;
    check("reset_async", dut_outs(), RESET_VEC);
    repeat (3) @(posedge refclk);
    #1;
    check("reset_hold", dut_outs(), RESET_VEC);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          lk;
    bit          sw;
    int          n;
    logic [18:0] exp;
  } vec_t;

  vec_t tbl[28];

  function automatic vec_t mk(input bit lk, input bit sw, input int n, input bit r,
                              input logic [3:0] c, input bit rdy, input bit flt,
                              input logic [3:0] rt, input logic [7:0] ls);
    vec_t v;
    v.lk = lk; v.sw = sw; v.n = n;
    v.exp = {r, c, rdy, flt, rt, ls};
    return v;
  endfunction

  initial begin
    bit found;
    // Clean power-up: lock 20 cycles after reset, staggered release, RUN.
    tbl[0]  = mk(0, 0, 1,   1, 4'h0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 7,   0, 4'h0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 12,  0, 4'h0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 19,  0, 4'h1, 0, 0, 0, 0);
    tbl[4]  = mk(1, 0, 3,   0, 4'h1, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 1,   0, 4'h3, 0, 0, 0, 0);
    tbl[6]  = mk(1, 0, 8,   0, 4'hF, 0, 0, 0, 0);
    tbl[7]  = mk(1, 0, 1,   0, 4'hF, 1, 0, 0, 0);
    // Lock loss in RUN: visible on the 3rd edge, then 8-cycle PLL reset.
    tbl[8]  = mk(0, 0, 2,   0, 4'hF, 1, 0, 0, 0);
    tbl[9]  = mk(0, 0, 1,   1, 4'h0, 0, 0, 0, 1);
    tbl[10] = mk(1, 0, 7,   1, 4'h0, 0, 0, 0, 1);
    tbl[11] = mk(1, 0, 1,   0, 4'h0, 0, 0, 0, 1);
    // Glitch after 10 stable cycles restarts the 16-cycle qualification.
    tbl[12] = mk(1, 0, 9,   0, 4'h0, 0, 0, 0, 1);
    tbl[13] = mk(0, 0, 1,   0, 4'h0, 0, 0, 0, 1);
    tbl[14] = mk(1, 0, 18,  0, 4'h0, 0, 0, 0, 1);
    tbl[15] = mk(1, 0, 1,   0, 4'h1, 0, 0, 0, 1);
    tbl[16] = mk(1, 0, 13,  0, 4'hF, 1, 0, 0, 1);
    // Restart coincident with lock loss: loss is not counted.
    tbl[17] = mk(0, 0, 2,   0, 4'hF, 1, 0, 0, 1);
    tbl[18] = mk(0, 1, 1,   1, 4'h0, 0, 0, 0, 1);
    tbl[19] = mk(0, 0, 1,   1, 4'h0, 0, 0, 0, 1);
    // Two timeouts -> FAULT, then software restart.
    tbl[20] = mk(0, 0, 106, 0, 4'h0, 0, 0, 0, 1);
    tbl[21] = mk(0, 0, 1,   1, 4'h0, 0, 0, 1, 1);
    tbl[22] = mk(0, 0, 107, 0, 4'h0, 0, 0, 1, 1);
    tbl[23] = mk(0, 0, 1,   1, 4'h0, 0, 1, 2, 1);
    tbl[24] = mk(0, 0, 20,  1, 4'h0, 0, 1, 2, 1);
    tbl[25] = mk(0, 1, 1,   1, 4'h0, 0, 0, 0, 1);
    tbl[26] = mk(0, 0, 7,   1, 4'h0, 0, 0, 0, 1);
    tbl[27] = mk(0, 0, 1,   0, 4'h0, 0, 0, 0, 1);

    #2;
    apply_reset();
    for (int v = 0; v < 28; v++) begin
      sup_if.pll_locked = tbl[v].lk;
      sup_if.sw_restart = tbl[v].sw;
      for (int k = 0; k < tbl[v].n; k++) begin
        tick();
        sup_if.sw_restart = 1'b0;
      end
      check($sformatf("vec%0d", v), dut_outs(), tbl[v].exp);
    end

    // Asynchronous reset in the middle of the staggered release.
    apply_reset();
    sup_if.pll_locked = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 80 && !found; k++) begin
      tick();
      if (m_phase == M_REL && m_el == 5) found = 1'b1;
    end
    check("reach_release", 19'(found), 19'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_release", dut_outs(), RESET_VEC);

    // Randomized lock activity and restarts.
    apply_reset();
    for (int k = 0; k < 5000; k++) begin
      if ($urandom_range(0, 39) == 0) sup_if.pll_locked = ~sup_if.pll_locked;
      sup_if.sw_restart = ($urandom_range(0, 299) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
